// File: rtl/pacman_soc_pkg.sv
// ---------------------------------------------------------------------------
// pacman_soc_pkg
// Shared constants for the pacman SoC Avalon-MM peripherals.
// Holds the word offsets of the event-input register map so that software
// headers and every peripheral decode the same addresses.
// ---------------------------------------------------------------------------
package pacman_soc_pkg;

    localparam int          AVL_DATA_W   = 32;

    // Event-input register map (word offsets)
    localparam logic [1:0]  REG_DATA     = 2'd0;  // RO: synchronized inputs
    localparam logic [1:0]  REG_IRQ_MASK = 2'd1;  // RW: per-bit interrupt enable
    localparam logic [1:0]  REG_RSVD     = 2'd2;  // reads 0, writes dropped
    localparam logic [1:0]  REG_EDGE_CAP = 2'd3;  // R / write-1-to-clear

endpackage

// File: rtl/pacman_soc_sync_bus.sv
// ---------------------------------------------------------------------------
// pacman_soc_sync_bus
// Multi-bit flop-chain synchronizer for asynchronous level inputs. Each bit
// is synchronized independently; no cross-bit coherence is implied.
//
// Ports
//   clk      in   clock, rising edge
//   reset    in   synchronous active-high reset, clears every stage
//   i_async  in   [WIDTH]  asynchronous inputs
//   o_sync   out  [WIDTH]  output of the final stage
// ---------------------------------------------------------------------------
module pacman_soc_sync_bus #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] r_chain;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_chain <= '0;
        end else begin
            r_chain[0] <= i_async;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_chain[i] <= r_chain[i-1];
            end
        end
    end

    assign o_sync = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/pacman_soc_event_in.sv
// ---------------------------------------------------------------------------
// pacman_soc_event_in
// Avalon-MM event-input peripheral: synchronizes asynchronous game events,
// latches rising edges into a sticky EDGE_CAPTURE register and raises a
// level interrupt when any captured, unmasked bit is set.
//
// Ports
//   clk         in   clock, rising edge
//   reset       in   synchronous active-high reset
//   address     in   [2]   word address (DATA, IRQ_MASK, RSVD, EDGE_CAPTURE)
//   chipselect  in   slave select
//   write_n     in   active-low write strobe
//   writedata   in   [32]  write data
//   readdata    out  [32]  combinational read data, zero-extended
//   in_port     in   [WIDTH] asynchronous event inputs
//   irq         out  registered |(EDGE_CAPTURE & IRQ_MASK)
// ---------------------------------------------------------------------------
module pacman_soc_event_in #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    import pacman_soc_pkg::*;

    logic [WIDTH-1:0]      w_sync;
    logic [WIDTH-1:0]      w_rise;
    logic [WIDTH-1:0]      w_clr;
    logic                  w_wr;
    logic [AVL_DATA_W-1:0] w_rdata;
    logic                  w_unused_wdata;

    logic [WIDTH-1:0]      r_prev;
    logic [WIDTH-1:0]      r_mask;
    logic [WIDTH-1:0]      r_cap;
    logic                  r_irq;

    pacman_soc_sync_bus #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset   (reset),
        .i_async (in_port),
        .o_sync  (w_sync)
    );

    assign w_wr   = chipselect & ~write_n;
    assign w_rise = w_sync & ~r_prev;

    // Upper writedata bits beyond WIDTH carry no meaning for this block.
    assign w_unused_wdata = ^writedata;

    always_comb begin
        w_clr = '0;
        if (w_wr && (address == REG_EDGE_CAP)) begin
            w_clr = writedata[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev <= '0;
            r_mask <= '0;
            r_cap  <= '0;
            r_irq  <= 1'b0;
        end else begin
            r_prev <= w_sync;
            // Clear is applied first so a coincident edge re-sets the bit.
            r_cap  <= (r_cap & ~w_clr) | w_rise;
            if (w_wr && (address == REG_IRQ_MASK)) begin
                r_mask <= writedata[WIDTH-1:0];
            end
            // Built from the current registers, so irq trails them by a cycle.
            r_irq  <= |(r_cap & r_mask);
        end
    end

    always_comb begin
        w_rdata = '0;
        case (address)
            REG_DATA:     w_rdata[WIDTH-1:0] = w_sync;
            REG_IRQ_MASK: w_rdata[WIDTH-1:0] = r_mask;
            REG_EDGE_CAP: w_rdata[WIDTH-1:0] = r_cap;
            default:      w_rdata            = '0;
        endcase
    end

    assign readdata = w_rdata;
    assign irq      = r_irq;

endmodule

// File: doc/pacman_soc_event_in.md
PACMAN_SOC_EVENT_IN -- requirements
Module: pacman_soc_event_in

Interface
REQ-001 SHALL expose parameter WIDTH, default 8: number of event input bits, range 1..32.
REQ-002 SHALL expose parameter SYNC_STAGES, default 2: depth of the input synchronizer, range 2..3.
REQ-003 SHALL provide port clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL provide port reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL provide port address  input  2  Avalon-MM slave word address.
REQ-006 SHALL provide port chipselect  input  1  slave select.
REQ-007 SHALL provide port write_n  input  1  active-low write strobe.
REQ-008 SHALL provide port writedata  input  32  write data.
REQ-009 SHALL provide port readdata  output  32  read data, zero-extended.
REQ-010 SHALL provide port in_port  input  WIDTH  asynchronous game-event inputs, e.g. collisions and pellet hits.
REQ-011 SHALL provide port irq  output  1  level interrupt to the CPU.

Function
REQ-012 SHALL pass in_port through a SYNC_STAGES-deep flop chain; the final stage is "sync".
REQ-013 SHALL hold "prev", a one-cycle-delayed copy of sync; a rising edge on bit i is sync[i] & ~prev[i].
REQ-014 Register map SHALL be: 0 = DATA (RO, sync); 1 = IRQ_MASK (RW, WIDTH bits); 2 = reserved (reads 0, writes ignored); 3 = EDGE_CAPTURE (R, write-1-to-clear).
REQ-015 readdata SHALL be combinational from address and the current register values (read latency 0); unused upper bits SHALL read 0.
REQ-016 A write SHALL occur when chipselect=1 and write_n=0; it SHALL take effect on the next rising clk.
REQ-017 A write to IRQ_MASK SHALL load writedata[WIDTH-1:0].
REQ-018 A write to EDGE_CAPTURE SHALL clear each bit i where writedata[i]=1; bits with writedata[i]=0 SHALL be unchanged.
REQ-019 EDGE_CAPTURE bit i SHALL set on a detected rising edge of bit i and SHALL stay set until cleared.
REQ-020 If bit i sees an edge in the same cycle as its clear, the set SHALL win and the bit SHALL remain 1.
REQ-021 Latency from an in_port rising transition to the EDGE_CAPTURE bit set SHALL be SYNC_STAGES+1 clk cycles.
REQ-022 irq SHALL be registered and equal to |(EDGE_CAPTURE & IRQ_MASK), lagging the capture/mask state by one cycle.
REQ-023 Falling edges and static levels SHALL NOT set EDGE_CAPTURE.
REQ-024 A pulse narrower than one clk period SHALL NOT be guaranteed to be captured.
REQ-025 Reads SHALL have no side effects.

Reset
REQ-026 While reset=1, at the next rising clk: sync chain, prev, IRQ_MASK, EDGE_CAPTURE and irq SHALL be 0.
REQ-027 Reset asserted mid-operation SHALL discard pending captures; writes in that cycle SHALL be ignored.
REQ-028 After reset deasserts, an input already high SHALL register as one rising edge once it propagates through the synchronizer, because prev resets to 0.

Structure
REQ-029 Register-offset constants (DATA=0, IRQ_MASK=1, RSVD=2, EDGE_CAPTURE=3) SHALL live in the shared pacman_soc package.
REQ-030 The synchronizer SHALL be a separate sub-module, pacman_soc_sync_bus (parameters WIDTH, SYNC_STAGES), reusable by other input ports.
REQ-031 No other sub-modules are required; irq SHALL be the only output besides readdata.

Verification
REQ-032 Reset, then read addresses 0..3 with in_port=0 -> each returns 0x00000000 and irq=0.
REQ-033 in_port 0x00->0x05 and held -> EDGE_CAPTURE=0x05 after 3 cycles; DATA reads 0x05; with mask 0, irq stays 0.
REQ-034 Write IRQ_MASK=0x04 with EDGE_CAPTURE=0x05 -> irq=1 one cycle after the mask write; write 0x04 to address 3 -> EDGE_CAPTURE=0x01 and irq=0 one cycle later.
REQ-035 Edge on bit 1 in the same cycle as a write of 0x02 to address 3 -> bit 1 stays 1 (set wins).
REQ-036 in_port 0xFF->0x00 -> no capture; read address 2 after writing 0xFFFFFFFF -> 0; write_n=0 with chipselect=0 -> no register change.
REQ-037 Assert reset with EDGE_CAPTURE=0x81 and mask 0xFF -> all registers 0 and irq=0 next cycle; after release with in_port held at 0x80 -> EDGE_CAPTURE=0x80.
